// File: rtl/piso_tx_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : piso_tx_pkg
//  Description : Shared types and helpers for the parallel-in/serial-out
//                transmitter (state encoding, bit-counter width).
//  Revision    : 1.0 - initial release
// ============================================================================
package piso_tx_pkg;

    // Two-state transmitter FSM
    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    // Width of the bit counter that indexes 0 .. width-1
    function automatic int cnt_width(input int width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

endpackage : piso_tx_pkg
`default_nettype wire

// File: rtl/piso_tx_if.sv
`default_nettype none
// ============================================================================
//  Module      : piso_tx_if
//  Description : Load handshake and serial output bundle of piso_tx.
//                master = producer/observer side, slave = transmitter side.
//  Revision    : 1.0 - initial release
// ============================================================================
interface piso_tx_if #(
    parameter int WIDTH = 4
);
    logic             load_valid;
    logic             load_ready;
    logic [WIDTH-1:0] load_data;
    logic             out;
    logic             out_valid;
    logic             busy;
    logic             done;

    modport master (
        output load_valid,
        output load_data,
        input  load_ready,
        input  out,
        input  out_valid,
        input  busy,
        input  done
    );

    modport slave (
        input  load_valid,
        input  load_data,
        output load_ready,
        output out,
        output out_valid,
        output busy,
        output done
    );
endinterface : piso_tx_if
`default_nettype wire

// File: rtl/piso_tx.sv
`default_nettype none
// ============================================================================
//  Module      : piso_tx
//  Description : Parallel-in/serial-out transmitter. Accepts a WIDTH-bit word
//                on a valid/ready handshake and shifts it out one bit per
//                clock with a bit-valid qualifier and a last-bit done pulse.
//                A word offered during the last-bit cycle is taken without a
//                gap, so back-to-back words stream continuously.
//  Revision    : 1.0 - initial release
// ============================================================================
module piso_tx
    import piso_tx_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter int MSB_FIRST = 1
)(
    input  wire logic clk,
    input  wire logic rst,
    piso_tx_if.slave  bus
);

    localparam int                 c_cnt_w = cnt_width(WIDTH);
    localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(WIDTH - 1);
    localparam logic [c_cnt_w-1:0] c_one   = c_cnt_w'(1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [WIDTH-1:0]   r_sreg;
    logic [WIDTH-1:0]   w_sreg_nxt;
    logic [WIDTH-1:0]   w_shifted;
    logic [c_cnt_w-1:0] r_cnt;
    logic [c_cnt_w-1:0] w_cnt_nxt;
    logic               w_last;
    logic               w_ready;
    logic               w_accept;
    logic               w_out_bit;

    if (WIDTH < 2) begin : g_width_check
        $error("piso_tx: WIDTH must be at least 2");
    end

    // The output end of the shift register depends on the bit order; the
    // register always moves toward that end and fills with zeros.
    if (MSB_FIRST != 0) begin : g_msb_first
        assign w_shifted = {r_sreg[WIDTH-2:0], 1'b0};
        assign w_out_bit = r_sreg[WIDTH-1];
    end else begin : g_lsb_first
        assign w_shifted = {1'b0, r_sreg[WIDTH-1:1]};
        assign w_out_bit = r_sreg[0];
    end

    // Ready depends only on registered state so the producer sees no loop
    assign w_last   = (r_state == ST_SHIFT) && (r_cnt == c_last);
    assign w_ready  = (r_state == ST_IDLE) || w_last;
    assign w_accept = bus.load_valid && w_ready;

    // Next-state, counter and shift-register update
    always_comb begin
        w_state_nxt = r_state;
        w_sreg_nxt  = r_sreg;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_sreg_nxt  = bus.load_data;
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (!w_last) begin
                    w_sreg_nxt = w_shifted;
                    w_cnt_nxt  = r_cnt + c_one;
                end else if (w_accept) begin
                    w_sreg_nxt = bus.load_data;
                    w_cnt_nxt  = '0;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State registers; reset discards any word in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_sreg  <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_sreg  <= w_sreg_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    assign bus.load_ready = w_ready;
    assign bus.out        = (r_state == ST_SHIFT) && w_out_bit;
    assign bus.out_valid  = (r_state == ST_SHIFT);
    assign bus.busy       = (r_state == ST_SHIFT);
    assign bus.done       = w_last;

endmodule : piso_tx
`default_nettype wire

// File: tb/tb_piso_tx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_piso_tx
//  Description : Self-checking bench for piso_tx. Two instances (MSB-first and
//                LSB-first) share one stimulus stream; a word/remaining-bits
//                model predicts every output each cycle, and directed frames
//                pin the model with hand-written bit sequences.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_piso_tx;

    localparam int W = 4;

    logic         clk      = 1'b0;
    logic         rst      = 1'b1;
    logic         tb_valid = 1'b0;
    logic [W-1:0] tb_data  = '0;

    int checks = 0;
    int errors = 0;
    bit en_cmp = 1'b0;

    // Model: the word being sent and how many of its bits remain, counting
    // the bit on the line in the current cycle.
    int           m_rem  = 0;
    logic [W-1:0] m_word = '0;
    bit           m_acc  = 1'b0;

    always #5 clk = ~clk;

    piso_tx_if #(.WIDTH(W)) bus_m ();
    piso_tx_if #(.WIDTH(W)) bus_l ();

    assign bus_m.load_valid = tb_valid;
    assign bus_m.load_data  = tb_data;
    assign bus_l.load_valid = tb_valid;
    assign bus_l.load_data  = tb_data;

    piso_tx #(.WIDTH(W), .MSB_FIRST(1)) u_dut_msb (
        .clk (clk),
        .rst (rst),
        .bus (bus_m)
    );

    piso_tx #(.WIDTH(W), .MSB_FIRST(0)) u_dut_lsb (
        .clk (clk),
        .rst (rst),
        .bus (bus_l)
    );

    task automatic chk(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s t=%0t actual=%b required=%b", name, $time, act, exp);
        end
    endtask

    // Reference model advanced at each rising edge
    always @(posedge clk) begin
        if (rst) begin
            m_rem = 0;
            m_acc = 1'b0;
        end else begin
            m_acc = tb_valid && (m_rem <= 1);
            if (m_acc) begin
                m_word = tb_data;
                m_rem  = W;
            end else if (m_rem > 0) begin
                m_rem = m_rem - 1;
            end
        end
    end

    // Compare both instances against the model every cycle
    always @(negedge clk) begin
        if (en_cmp) begin
            chk("m_out",   bus_m.out,        (m_rem > 0) ? m_word[m_rem-1] : 1'b0);
            chk("l_out",   bus_l.out,        (m_rem > 0) ? m_word[W-m_rem] : 1'b0);
            chk("m_valid", bus_m.out_valid,  m_rem > 0);
            chk("l_valid", bus_l.out_valid,  m_rem > 0);
            chk("m_busy",  bus_m.busy,       m_rem > 0);
            chk("l_busy",  bus_l.busy,       m_rem > 0);
            chk("m_done",  bus_m.done,       m_rem == 1);
            chk("l_done",  bus_l.done,       m_rem == 1);
            chk("m_ready", bus_m.load_ready, m_rem <= 1);
            chk("l_ready", bus_l.load_ready, m_rem <= 1);
        end
    end

    task automatic idle(input int n);
        tb_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    // Offer w0 now, optionally offer w1 from cycle second_at+1 and hold it
    // until taken; compare against literal per-cycle strings ("1"/"0").
    task automatic directed(input string name, input logic [W-1:0] w0,
                            input logic [W-1:0] w1, input int second_at,
                            input int ncyc, input string e_m, input string e_l,
                            input string e_v, input string e_d, input string e_r);
        idle(3);
        tb_valid = 1'b1;
        tb_data  = w0;
        for (int k = 0; k < ncyc; k++) begin
            @(negedge clk);
            if (tb_valid && m_acc) tb_valid = 1'b0;
            chk({name, "_out_msb"}, bus_m.out,        e_m[k] == "1");
            chk({name, "_out_lsb"}, bus_l.out,        e_l[k] == "1");
            chk({name, "_valid"},   bus_m.out_valid,  e_v[k] == "1");
            chk({name, "_done"},    bus_m.done,       e_d[k] == "1");
            chk({name, "_ready"},   bus_m.load_ready, e_r[k] == "1");
            if (k == second_at) begin
                tb_valid = 1'b1;
                tb_data  = w1;
            end
        end
    endtask

    initial begin
        // Reset held three cycles
        rst = 1'b1;
        repeat (3) @(negedge clk);
        en_cmp = 1'b1;
        rst    = 1'b0;
        @(negedge clk);
        chk("rst_out",   bus_m.out,        1'b0);
        chk("rst_valid", bus_m.out_valid,  1'b0);
        chk("rst_busy",  bus_m.busy,       1'b0);
        chk("rst_done",  bus_m.done,       1'b0);
        chk("rst_ready", bus_m.load_ready, 1'b1);

        // Single word 1011: MSB-first 1,0,1,1 / LSB-first 1,1,0,1
        directed("single", 4'b1011, 4'b0000, -1, 5,
                 "10110", "11010", "11110", "00010", "00011");

        // Gapless back-to-back 1011 then 0110
        directed("b2b", 4'b1011, 4'b0110, 3, 9,
                 "101101100", "110101100", "111111110", "000100010", "000100011");

        // Backpressure: 1111 offered from cycle 1, taken only at the last bit
        directed("bp", 4'b1000, 4'b1111, 0, 9,
                 "100011110", "000111110", "111111110", "000100010", "000100011");

        // Reset in the middle of a word; a coincident offer is dropped
        idle(3);
        tb_valid = 1'b1;
        tb_data  = 4'b1111;
        @(negedge clk);
        tb_valid = 1'b0;
        @(negedge clk);
        rst      = 1'b1;
        tb_valid = 1'b1;
        tb_data  = 4'b0101;
        @(negedge clk);
        chk("rmid_out",   bus_m.out,        1'b0);
        chk("rmid_valid", bus_m.out_valid,  1'b0);
        chk("rmid_busy",  bus_m.busy,       1'b0);
        chk("rmid_done",  bus_m.done,       1'b0);
        chk("rmid_ready", bus_m.load_ready, 1'b1);
        rst      = 1'b0;
        tb_valid = 1'b0;
        @(negedge clk);
        chk("rmid_done2", bus_m.done,       1'b0);
        chk("rmid_busy2", bus_m.busy,       1'b0);

        // Randomized traffic with occasional resets
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            rst = 1'b0;
            if (tb_valid && m_acc) tb_valid = 1'b0;
            if ($urandom_range(0, 99) == 0) rst = 1'b1;
            if (!tb_valid && ($urandom_range(0, 2) == 0)) begin
                tb_valid = 1'b1;
                tb_data  = W'($urandom);
            end
        end
        rst = 1'b0;
        idle(8);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_piso_tx
`default_nettype wire
